// File: rtl/pad_io_filter.sv
// pad_io_filter: pad output registering plus synchronised, masked, debounced pad input with edge pulses.
// Optional glitch statistics port and counter are enabled by defining PAD_IO_FILTER_STATS_EN.
module pad_io_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CNT_W  = 8,
  parameter int   TURN_CYCLES = 2,
  parameter logic PULL_EN     = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
`ifdef PAD_IO_FILTER_STATS_EN
  input  logic                  glitch_clr_i,
  output logic [15:0]           glitch_cnt_o,
`endif
  input  logic                  oe_i,
  input  logic                  out_i,
  input  logic [FILT_CNT_W-1:0] filt_len_i,
  output logic                  in_o,
  output logic                  rise_o,
  output logic                  fall_o,
  output logic                  pad_i_o,
  output logic                  pad_oen_o,
  output logic                  pad_pen_o,
  input  logic                  pad_o_i
);
  typedef enum logic {IDLE, PEND} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] s;
  logic [FILT_CNT_W-1:0] cnt, cnt_n;
  logic [3:0] tcnt;
  logic sync, mask, acc, in_n, rise_n, fall_n;
  assign pad_pen_o = PULL_EN;
  assign sync = s[SYNC_STAGES-1];
  assign mask = !pad_oen_o || tcnt != 4'd0;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      pad_oen_o <= 1'b1;
      pad_i_o   <= 1'b0;
      s         <= '0;
      tcnt      <= 4'd0;
    end else begin
      pad_oen_o <= ~oe_i;
      pad_i_o   <= out_i;
      s         <= {s[SYNC_STAGES-2:0], pad_o_i};
      // load the turnaround window on the edge where the driver releases
      tcnt      <= (!pad_oen_o && !oe_i) ? 4'(TURN_CYCLES) : (tcnt != 4'd0) ? tcnt - 4'd1 : tcnt;
    end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      in_o   <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      in_o   <= in_n;
      rise_o <= rise_n;
      fall_o <= fall_n;
    end
  always_comb begin
    acc     = 1'b0;
    state_n = state;
    cnt_n   = cnt;
    if (state == IDLE) begin
      if (!mask && sync != in_o) begin
        if (filt_len_i == '0) acc = 1'b1;
        else begin
          cnt_n   = FILT_CNT_W'(1);
          state_n = PEND;
        end
      end
    end else if (mask || sync == in_o) begin
      cnt_n   = '0;
      state_n = IDLE;
    end else if (cnt >= filt_len_i) begin
      acc     = 1'b1;
      cnt_n   = '0;
      state_n = IDLE;
    end else cnt_n = cnt + FILT_CNT_W'(1);
  end
  always_comb begin
    in_n   = acc ? sync : in_o;
    rise_n = acc && sync;
    fall_n = acc && !sync;
  end
`ifdef PAD_IO_FILTER_STATS_EN
  logic glitch;
  assign glitch = state == PEND && !mask && sync == in_o;
  always_ff @(posedge clk_i)
    if (rst_i || glitch_clr_i) glitch_cnt_o <= 16'd0;
    else if (glitch && glitch_cnt_o != 16'hFFFF) glitch_cnt_o <= glitch_cnt_o + 16'd1;
`else
`endif
endmodule

// File: tb/tb_pad_io_filter.sv
// tb_pad_io_filter: directed vectors for pad_io_filter at default parameters.
module tb_pad_io_filter;
  logic clk = 1'b0, rst, oe, out, pad, glitch_clr;
  logic [7:0] filt;
  logic in_o, rise, fall, pad_i, pad_oen, pad_pen;
  logic [15:0] glitch_cnt;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  pad_io_filter dut (
    .clk_i(clk),
    .rst_i(rst),
`ifdef PAD_IO_FILTER_STATS_EN
    .glitch_clr_i(glitch_clr),
    .glitch_cnt_o(glitch_cnt),
`endif
    .oe_i(oe),
    .out_i(out),
    .filt_len_i(filt),
    .in_o(in_o),
    .rise_o(rise),
    .fall_o(fall),
    .pad_i_o(pad_i),
    .pad_oen_o(pad_oen),
    .pad_pen_o(pad_pen),
    .pad_o_i(pad)
  );
`ifndef PAD_IO_FILTER_STATS_EN
  assign glitch_cnt = 16'd0;
`endif
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic p(input int i);
    return i[2];
  endfunction
  initial begin
    rst = 1'b1; oe = 1'b0; out = 1'b0; pad = 1'b0; glitch_clr = 1'b0; filt = 8'd0;
    step(3);
    chk("rst_oen", {15'd0, pad_oen}, 16'd1);
    chk("rst_padi", {15'd0, pad_i}, 16'd0);
    chk("rst_in", {15'd0, in_o}, 16'd0);
    chk("rst_pulse", {14'd0, rise, fall}, 16'd0);
    chk("pen", {15'd0, pad_pen}, 16'd0);
    chk("rst_glitch", glitch_cnt, 16'd0);
    rst = 1'b0;
    step(4);
    oe = 1'b1; out = 1'b1;
    chk("oen_pre", {15'd0, pad_oen}, 16'd1);
    step(1);
    chk("oen_drive", {15'd0, pad_oen}, 16'd0);
    chk("padi_drive", {15'd0, pad_i}, 16'd1);
    out = 1'b0;
    step(1);
    chk("padi_low", {15'd0, pad_i}, 16'd0);
    oe = 1'b0;
    step(1);
    chk("oen_release", {15'd0, pad_oen}, 16'd1);
    step(5);
    filt = 8'd3; pad = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk("deb_in", {15'd0, in_o}, {15'd0, k >= 6});
      chk("deb_rise", {15'd0, rise}, {15'd0, k == 6});
      chk("deb_fall", {15'd0, fall}, 16'd0);
    end
    pad = 1'b0;
    step(10);
    chk("deb_back", {15'd0, in_o}, 16'd0);
    pad = 1'b1;
    step(3);
    pad = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      chk("gl_in", {15'd0, in_o}, 16'd0);
      chk("gl_rise", {15'd0, rise}, 16'd0);
    end
`ifdef PAD_IO_FILTER_STATS_EN
    chk("gl_cnt", glitch_cnt, 16'd1);
    glitch_clr = 1'b1;
    step(1);
    glitch_clr = 1'b0;
    chk("gl_clr", glitch_cnt, 16'd0);
`endif
    filt = 8'd0;
    for (int i = 0; i < 24; i++) begin
      pad = p(i);
      step(1);
      if (i + 1 >= 4) begin
        chk("pt_in", {15'd0, in_o}, {15'd0, p(i - 2)});
        chk("pt_rise", {15'd0, rise}, {15'd0, p(i - 2) && !p(i - 3)});
        chk("pt_fall", {15'd0, fall}, {15'd0, !p(i - 2) && p(i - 3)});
      end
    end
    step(3);
    oe = 1'b1;
    step(1);
    chk("ta_oen", {15'd0, pad_oen}, 16'd0);
    for (int i = 0; i < 12; i++) begin
      pad = (i < 8) ? ~pad : 1'b0;
      step(1);
      chk("ta_frozen", {15'd0, in_o}, 16'd1);
      chk("ta_nofall", {15'd0, fall}, 16'd0);
    end
    oe = 1'b0;
    step(1);
    chk("ta_rel", {15'd0, pad_oen}, 16'd1);
    chk("ta_hold0", {15'd0, in_o}, 16'd1);
    step(1);
    chk("ta_hold1", {15'd0, in_o}, 16'd1);
    step(1);
    chk("ta_hold2", {15'd0, in_o}, 16'd1);
    step(1);
    chk("ta_in", {15'd0, in_o}, 16'd0);
    chk("ta_fall", {15'd0, fall}, 16'd1);
    step(3);
    filt = 8'd200; pad = 1'b1;
    step(12);
    chk("fr_wait", {15'd0, in_o}, 16'd0);
    filt = 8'd2;
    step(1);
    chk("fr_in", {15'd0, in_o}, 16'd1);
    chk("fr_rise", {15'd0, rise}, 16'd1);
    step(1);
    chk("fr_once", {15'd0, rise}, 16'd0);
    filt = 8'd5; pad = 1'b0;
    step(5);
    rst = 1'b1; pad = 1'b1;
    step(1);
    chk("mr_in", {15'd0, in_o}, 16'd0);
    chk("mr_pulse", {14'd0, rise, fall}, 16'd0);
    step(1);
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      chk("hr_in", {15'd0, in_o}, {15'd0, k >= 8});
      chk("hr_rise", {15'd0, rise}, {15'd0, k == 8});
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pad_io_filter.md
Name: pad_io_filter

Overview:
- Core-side conditioning stage that sits directly in front of a functional pad cell (OEN/I/O/PEN interface).
- Output direction: registers core data and output-enable, and drives the pad's active-low OEN and its I input.
- Input direction: synchronises the pad's O output, masks it during drive and bus turnaround, debounces it with a programmable stable-time filter, and emits one-cycle edge pulses.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on the pad input; legal range 2..4.
- FILT_CNT_W, 8, width of the debounce counter and of filt_len_i.
- TURN_CYCLES, 2, cycles the input stays masked after the output driver releases; legal range 0..15.
- PULL_EN, 1'b0, constant value driven on pad_pen_o.

Ports:
- clk_i, in, 1, single clock.
- rst_i, in, 1, synchronous active-high reset.
- oe_i, in, 1, core output enable; 1 = drive pad.
- out_i, in, 1, core output data.
- filt_len_i, in, FILT_CNT_W, debounce length; a change is accepted only after filt_len_i+1 consecutive differing samples.
- in_o, out, 1, filtered pad input.
- rise_o, out, 1, one-cycle pulse when in_o goes 0->1.
- fall_o, out, 1, one-cycle pulse when in_o goes 1->0.
- pad_i_o, out, 1, to pad I.
- pad_oen_o, out, 1, to pad OEN; active-low enable, so 1 = tristate.
- pad_pen_o, out, 1, to pad PEN.
- pad_o_i, in, 1, from pad O; asynchronous.

Behaviour:
- All flops use clk_i with synchronous active-high rst_i.
- Reset values:
  - pad_oen_o = 1; pad_i_o = 0.
  - Synchroniser flops = 0; in_o = 0; rise_o = fall_o = 0.
  - Debounce counter cnt = 0; turnaround counter tcnt = 0.
- pad_pen_o = PULL_EN, combinational constant.
- Output path, 1-cycle latency:
  - pad_oen_o <= ~oe_i.
  - pad_i_o <= out_i.
  - No other gating.
- Sync: s[0] <= pad_o_i; s[k] <= s[k-1]; sync = s[SYNC_STAGES-1].
- Mask:
  - mask = (pad_oen_o == 0) || (tcnt != 0).
  - When pad_oen_o goes 0->1 (driver releases), tcnt <= TURN_CYCLES; otherwise tcnt decrements to 0 and saturates there.
  - TURN_CYCLES = 0 means mask follows pad_oen_o only.
  - Re-enabling the driver while tcnt != 0 keeps mask high; tcnt continues decrementing.
- Filter FSM, states IDLE / PEND:
  - IDLE: cnt = 0. If !mask && sync != in_o: if filt_len_i == 0, accept; else cnt <= 1 and go to PEND.
  - PEND, when sync == in_o or mask = 1: cnt <= 0, go to IDLE (glitch discarded).
  - PEND, when cnt >= filt_len_i: accept.
  - PEND, otherwise: cnt <= cnt + 1.
  - Use >=, not ==, so that reducing filt_len_i mid-count resolves on the next cycle.
  - cnt never exceeds 2^FILT_CNT_W - 1.
- Accept: in_o <= sync; rise_o or fall_o = 1 for exactly that one cycle; cnt <= 0; go to IDLE.
- Latency from pad_o_i edge to in_o, with mask = 0: SYNC_STAGES + filt_len_i + 1 cycles.
- While masked, in_o holds its last value and no pulses are produced.
- rise_o and fall_o are never asserted together.
- Reset mid-PEND returns the filter to IDLE; in_o = 0 with no pulse.
- If the pad is high at reset release, rise_o fires after the normal filter latency.

Optional Feature:
- Macro: PAD_IO_FILTER_STATS_EN.
- Defined:
  - Adds port glitch_cnt_o, out, 16, plus input glitch_clr_i, in, 1.
  - glitch_cnt_o increments on every PEND->IDLE transition caused by sync == in_o; mask aborts do not count.
  - glitch_cnt_o saturates at 0xFFFF.
  - glitch_clr_i zeroes it next cycle; clear wins over a simultaneous increment.
  - Reset value 0.
- Undefined: these ports and the counter do not exist; all other behaviour is identical.

Test Plan:
- Output path: reset, then oe_i = 1, out_i = 1 at cycle 5 -> pad_oen_o = 0 and pad_i_o = 1 at cycle 6. Reset -> pad_oen_o = 1.
- Debounce, filt_len_i = 3, SYNC_STAGES = 2, pad_o_i 0->1 held -> in_o = 1 exactly 6 cycles later, with a single rise_o pulse in that same cycle.
- Glitch reject, filt_len_i = 3, pad_o_i high for 3 cycles then low -> in_o stays 0, no pulse; glitch_cnt_o = 1 when the macro is defined.
- Pass-through, filt_len_i = 0 -> pad toggling every 4 cycles produces in_o with matching toggles at 3-cycle latency, alternating rise_o/fall_o pulses.
- Turnaround, TURN_CYCLES = 2: drive with oe_i = 1 while pad_o_i toggles -> in_o frozen. Release -> input is ignored for 2 cycles after pad_oen_o returns to 1, then filtered normally.
- filt_len_i reduced from 200 to 2 while cnt = 10 -> accept on the next cycle. rst_i asserted mid-PEND -> in_o = 0, cnt = 0, no pulse.
